// File: rtl/autotest_pkg.sv
// Shared types and widths for the PRESENT autotest datapath.
// Holds the capture FSM state encoding and the cipher block/key widths.
package autotest_pkg;

  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cap_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
// Latency: dout updates one cycle after clr/en; clr has priority over en.
// Backpressure: none, en simply stalls the count.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout <= '0;
    end else if (clr) begin
      dout <= '0;
    end else if (en && !(&dout)) begin
      dout <= dout + WIDTH'(1);
    end
  end

endmodule

// File: rtl/uut_result_capture.sv
// Measures UUT latency from rst_uut release to its done flag and holds the result.
// Latency: all outputs registered, result_valid rises the cycle after the done flag.
// Backpressure: result held in DONE until result_ack; new starts ignored meanwhile.
module uut_result_capture
  import autotest_pkg::*;
#(
  parameter int          CNT_WIDTH      = 32,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rst_uut,
  input  logic                 encdec_uut,
  input  logic                 end_enc_uut,
  input  logic                 end_dec_uut,
  input  logic [BLOCK_W-1:0]   block_o_uut,
  input  logic                 result_ack,
  output logic                 result_valid,
  output logic [BLOCK_W-1:0]   result_block,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic                 timeout,
  output logic                 busy
);

  localparam logic [CNT_WIDTH-1:0] TO_LIM = CNT_WIDTH'(TIMEOUT_CYCLES);

  cap_state_t           state;
  cap_state_t           state_nxt;
  logic                 rst_uut_q;
  logic                 op_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 done_flag;
  logic                 start;
  logic                 cap_done;
  logic                 cap_to;

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (start),
    .en   (state == RUN),
    .dout (cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    cap_done  = 1'b0;
    cap_to    = 1'b0;
    done_flag = op_q ? end_enc_uut : end_dec_uut;
    cnt_inc   = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
    case (state)
      IDLE: begin
        if (rst_uut_q && !rst_uut) begin
          start     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // A reasserted UUT reset abandons the measurement outright.
        if (rst_uut) begin
          state_nxt = IDLE;
        end else if (done_flag) begin
          cap_done  = 1'b1;
          state_nxt = DONE;
        end else if (cnt_inc == TO_LIM) begin
          cap_to    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (result_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rst_uut_q    <= 1'b0;
      op_q         <= 1'b0;
      result_block <= '0;
      cycle_count  <= '0;
      timeout      <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // Frozen in DONE so a rst_uut toggle there cannot arm a new run.
      if (state != DONE) begin
        rst_uut_q <= rst_uut;
      end
      if (start) begin
        op_q <= encdec_uut;
      end
      if (cap_done) begin
        result_block <= block_o_uut;
        cycle_count  <= cnt_inc;
        timeout      <= 1'b0;
      end else if (cap_to) begin
        result_block <= '0;
        cycle_count  <= TO_LIM;
        timeout      <= 1'b1;
      end
      result_valid <= (state_nxt == DONE);
      busy         <= (state_nxt == RUN);
    end
  end

endmodule

// File: tb/tb_uut_result_capture.sv
// Bench for uut_result_capture: a main instance (timeout 100) and a 4-bit
// instance whose timeout truncates to 0, so its counter can saturate.
module tb_uut_result_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst_uut = 1'b0;
  logic        encdec_uut = 1'b0;
  logic        end_enc_uut = 1'b0;
  logic        end_dec_uut = 1'b0;
  logic [63:0] block_o_uut = '0;
  logic        result_ack = 1'b0;

  logic        m_valid, m_timeout, m_busy;
  logic [63:0] m_block;
  logic [31:0] m_count;
  logic        s_valid, s_timeout, s_busy;
  logic [63:0] s_block;
  logic [3:0]  s_count;

  bit          sel = 1'b0;
  logic        r_valid, r_timeout, r_busy;
  logic [63:0] r_block;
  logic [31:0] r_count;

  assign r_valid   = sel ? s_valid   : m_valid;
  assign r_timeout = sel ? s_timeout : m_timeout;
  assign r_busy    = sel ? s_busy    : m_busy;
  assign r_block   = sel ? s_block   : m_block;
  assign r_count   = sel ? {28'd0, s_count} : m_count;

  always #5 clk = ~clk;

  uut_result_capture #(.CNT_WIDTH(32), .TIMEOUT_CYCLES(32'd100)) u_main (
    .clk(clk), .rst(rst), .rst_uut(rst_uut), .encdec_uut(encdec_uut),
    .end_enc_uut(end_enc_uut), .end_dec_uut(end_dec_uut), .block_o_uut(block_o_uut),
    .result_ack(result_ack), .result_valid(m_valid), .result_block(m_block),
    .cycle_count(m_count), .timeout(m_timeout), .busy(m_busy)
  );

  uut_result_capture #(.CNT_WIDTH(4), .TIMEOUT_CYCLES(32'd16)) u_small (
    .clk(clk), .rst(rst), .rst_uut(rst_uut), .encdec_uut(encdec_uut),
    .end_enc_uut(end_enc_uut), .end_dec_uut(end_dec_uut), .block_o_uut(block_o_uut),
    .result_ack(result_ack), .result_valid(s_valid), .result_block(s_block),
    .cycle_count(s_count), .timeout(s_timeout), .busy(s_busy)
  );

  typedef struct {
    bit          sel;
    bit          op;
    int          enc_at;
    int          dec_at;
    logic [63:0] blk;
    logic [31:0] exp_count;
    bit          exp_to;
    logic [63:0] exp_blk;
    int          exp_edge;
  } vec_t;

  typedef struct {
    logic [31:0] count;
    bit          to;
    logic [63:0] blk;
    int          lat_edge;
  } exp_t;

  vec_t vecs[8];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    int   seen;
    seen       = -1;
    sel        = v.sel;
    e.count    = v.exp_count;
    e.to       = v.exp_to;
    e.blk      = v.exp_blk;
    e.lat_edge = v.exp_edge;
    sb_q.push_back(e);
    @(negedge clk);
    rst_uut = 1'b1; encdec_uut = v.op; block_o_uut = v.blk;
    @(negedge clk);
    rst_uut = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1) chk($sformatf("v%0d busy", idx), r_busy, 1);
      if (r_valid) begin
        seen = k - 1;
        break;
      end
      end_enc_uut = (k == v.enc_at);
      end_dec_uut = (k == v.dec_at);
    end
    end_enc_uut = 1'b0;
    end_dec_uut = 1'b0;
    e = sb_q.pop_front();
    if (seen < 0) begin
      chk($sformatf("v%0d result_valid within bound", idx), 0, 1);
    end else begin
      chk($sformatf("v%0d cycle_count", idx), r_count, e.count);
      chk($sformatf("v%0d timeout", idx), r_timeout, e.to);
      chk($sformatf("v%0d result_block", idx), r_block, e.blk);
      chk($sformatf("v%0d latency edge", idx), seen, e.lat_edge);
      chk($sformatf("v%0d busy in DONE", idx), r_busy, 0);
    end
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    rst_uut    = 1'b1;
    chk($sformatf("v%0d valid drop", idx), r_valid, 0);
    chk($sformatf("v%0d count kept", idx), r_count, e.count);
    @(negedge clk);
  endtask

  initial begin
    bit          bad;
    logic [63:0] hb;

    vecs[0] = '{0, 1, 32,  0, 64'h5579C1387B228445, 32,  0, 64'h5579C1387B228445, 32};
    vecs[1] = '{0, 0,  5, 40, 64'hA5A5_0F0F_1234_5678, 40,  0, 64'hA5A5_0F0F_1234_5678, 40};
    vecs[2] = '{0, 1,  0,  0, 64'hDEAD_BEEF_CAFE_F00D, 100, 1, 64'h0, 100};
    vecs[3] = '{0, 1, 100, 0, 64'h1111_2222_3333_4444, 100, 0, 64'h1111_2222_3333_4444, 100};
    vecs[4] = '{0, 0,  0,  1, 64'h0000_0000_0000_0001, 1,   0, 64'h0000_0000_0000_0001, 1};
    vecs[5] = '{0, 1, 99,  7, 64'hFEDC_BA98_7654_3210, 99,  0, 64'hFEDC_BA98_7654_3210, 99};
    vecs[6] = '{1, 1, 20,  0, 64'h0F0F_F0F0_0F0F_F0F0, 15,  0, 64'h0F0F_F0F0_0F0F_F0F0, 20};
    vecs[7] = '{1, 0,  3,  9, 64'h7777_8888_9999_AAAA, 9,   0, 64'h7777_8888_9999_AAAA, 9};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset valid", m_valid, 0);
    chk("reset busy", m_busy, 0);
    chk("reset count", m_count, 0);
    chk("reset timeout", m_timeout, 0);
    chk("reset block", m_block, 0);
    rst = 1'b1;
    @(negedge clk);

    // Abort by rst_uut at RUN cycle 10
    sel = 1'b0;
    rst_uut = 1'b1; encdec_uut = 1'b1; block_o_uut = 64'h1234;
    @(negedge clk);
    rst_uut = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort busy before", m_busy, 1);
    repeat (5) @(negedge clk);
    rst_uut = 1'b1;
    @(negedge clk);
    chk("abort busy after", m_busy, 0);
    bad = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (m_valid || m_busy) bad = 1'b1;
    end
    chk("abort no result", bad, 0);
    run_vec(vecs[0], 100);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Hold in DONE for 20 cycles with rst_uut toggling
    sel = 1'b0;
    hb  = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    rst_uut = 1'b1; encdec_uut = 1'b1; block_o_uut = hb;
    @(negedge clk);
    rst_uut = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    end_enc_uut = 1'b1;
    @(negedge clk);
    end_enc_uut = 1'b0;
    chk("hold valid", m_valid, 1);
    chk("hold count", m_count, 3);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 5)  rst_uut = 1'b1;
      if (i == 10) rst_uut = 1'b0;
      if (i == 15) rst_uut = 1'b1;
      block_o_uut = {$urandom, $urandom};
      end_enc_uut = i[0];
      if (m_valid !== 1'b1 || m_count !== 32'd3 || m_block !== hb || m_timeout !== 1'b0)
        bad = 1'b1;
    end
    end_enc_uut = 1'b0;
    chk("hold stable", bad, 0);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    rst_uut    = 1'b0;
    chk("hold valid drop", m_valid, 0);
    chk("hold block kept", m_block, hb);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_busy || m_valid) bad = 1'b1;
    end
    chk("no run from DONE toggle", bad, 0);

    // rst low mid-RUN
    @(negedge clk);
    rst_uut = 1'b1;
    @(negedge clk);
    rst_uut = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre-reset busy", m_busy, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid reset busy", m_busy, 0);
    chk("mid reset valid", m_valid, 0);
    chk("mid reset block", m_block, 0);
    chk("mid reset count", m_count, 0);
    chk("mid reset timeout", m_timeout, 0);
    rst = 1'b1;
    @(negedge clk);
    run_vec(vecs[1], 101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
